observer_pio_master: RTL and testbench

//  Avalon-MM initiator that drives the observer CPU's 8-bit LED/GPIO output PIO from fabric logic (no Nios in the path).

---
 rtl/observer_pio_pkg.sv | 42 ++++
 rtl/observer_pio_master.sv | 126 ++++++++++++
 tb/tb_observer_pio_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/observer_pio_pkg.sv
// Shared definitions for the observer CPU PIO master: command codes, PIO
// register offsets, FSM states and the shadow update rule.
package observer_pio_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_SET   = 2'd1,
      OP_CLEAR = 2'd2,
      OP_READ  = 2'd3
   } op_e;

   localparam logic [2:0] ADDR_DATA = 3'd0;
   localparam logic [2:0] ADDR_SET  = 3'd4;
   localparam logic [2:0] ADDR_CLR  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_RDWAIT = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   function automatic logic [2:0] op_addr(input op_e op);
      case (op)
         OP_SET:   return ADDR_SET;
         OP_CLEAR: return ADDR_CLR;
         default:  return ADDR_DATA;
      endcase
   endfunction

   // Port value the PIO holds once a write-type command completes.
   function automatic logic [7:0] apply_op(input op_e op, input logic [7:0] cur,
                                           input logic [7:0] arg);
      case (op)
         OP_WRITE: return arg;
         OP_SET:   return cur | arg;
         OP_CLEAR: return cur & ~arg;
         default:  return cur;
      endcase
   endfunction

endpackage

// File: rtl/observer_pio_master.sv
// Avalon-MM initiator driving the observer CPU's 8-bit output PIO from fabric
// commands, keeping a shadow of the port and returning one response per command.
module observer_pio_master
   import observer_pio_pkg::*;
#(
   parameter int READ_LATENCY   = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_err,
   output logic [7:0]  shadow,
   output logic [2:0]  avm_address,
   output logic        avm_write,
   output logic        avm_read,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam int LAT_W = $clog2(READ_LATENCY + 2);

   state_e             state, state_nxt;
   op_e                op_q;
   logic [7:0]         data_q;
   logic [CNT_W-1:0]   wait_cnt;
   logic [LAT_W-1:0]   lat_cnt;
   logic               accept, complete, timeout_hit, lat_done, rd_capture, is_read;
   logic               unused_rd_hi;

   assign is_read       = (op_q == OP_READ);
   assign avm_address   = op_addr(op_q);
   assign avm_writedata = {24'b0, data_q};
   assign rsp_valid     = (state == ST_RESP);
   assign rd_capture    = (complete && is_read && (READ_LATENCY == 0)) || lat_done;
   assign unused_rd_hi  = ^avm_readdata[31:8];

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      cmd_ready   = 1'b0;
      avm_write   = 1'b0;
      avm_read    = 1'b0;
      accept      = 1'b0;
      complete    = 1'b0;
      timeout_hit = 1'b0;
      lat_done    = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            avm_write = !is_read;
            avm_read  = is_read;
            if (!avm_waitrequest) begin
               complete  = 1'b1;
               state_nxt = (is_read && READ_LATENCY > 0) ? ST_RDWAIT : ST_RESP;
            end else if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_hit = 1'b1;
               state_nxt   = ST_RESP;
            end
         end
         ST_RDWAIT: begin
            if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
               lat_done  = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Command latch, stall/latency counters, shadow and response capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q     <= OP_WRITE;
         data_q   <= 8'h00;
         wait_cnt <= '0;
         lat_cnt  <= '0;
         shadow   <= 8'h00;
         rsp_data <= 8'h00;
         rsp_err  <= 1'b0;
      end else begin
         if (accept) begin
            op_q     <= op_e'(cmd_op);
            data_q   <= cmd_data;
            wait_cnt <= '0;
         end else if (state == ST_REQ && avm_waitrequest) begin
            wait_cnt <= wait_cnt + 1'b1;
         end

         if (state == ST_REQ)         lat_cnt <= '0;
         else if (state == ST_RDWAIT) lat_cnt <= lat_cnt + 1'b1;

         if (complete && !is_read) begin
            shadow   <= apply_op(op_q, shadow, data_q);
            rsp_data <= apply_op(op_q, shadow, data_q);
            rsp_err  <= 1'b0;
         end
         if (timeout_hit) begin
            rsp_data <= shadow;
            rsp_err  <= 1'b1;
         end
         if (rd_capture) begin
            rsp_data <= avm_readdata[7:0];
            rsp_err  <= (avm_readdata[7:0] != shadow);
         end
      end
   end

endmodule

// File: tb/tb_observer_pio_master.sv
// Bench for observer_pio_master: a transaction-level model drives per-cycle
// expectations for a latency-0 instance; a latency-2 instance checks read timing.
module tb_observer_pio_master;

   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A: READ_LATENCY=0, TIMEOUT_CYCLES=8
   logic        a_valid, a_ready, a_rv, a_rerr, a_wr, a_rd, a_wreq;
   logic [1:0]  a_op;
   logic [7:0]  a_data, a_rsp_data, a_shadow;
   logic [2:0]  a_addr;
   logic [31:0] a_wd, a_rdata;

   observer_pio_master #(.READ_LATENCY(0), .TIMEOUT_CYCLES(TO)) dut_a (
      .clk(clk), .reset(rst),
      .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_op(a_op), .cmd_data(a_data),
      .rsp_valid(a_rv), .rsp_data(a_rsp_data), .rsp_err(a_rerr), .shadow(a_shadow),
      .avm_address(a_addr), .avm_write(a_wr), .avm_read(a_rd), .avm_writedata(a_wd),
      .avm_readdata(a_rdata), .avm_waitrequest(a_wreq)
   );

   // Instance B: READ_LATENCY=2, no timeout
   logic        b_valid, b_ready, b_rv, b_rerr, b_wr, b_rd;
   logic [1:0]  b_op;
   logic [7:0]  b_data, b_rsp_data, b_shadow;
   logic [2:0]  b_addr;
   logic [31:0] b_wd, b_rdata;

   observer_pio_master #(.READ_LATENCY(2), .TIMEOUT_CYCLES(0)) dut_b (
      .clk(clk), .reset(rst),
      .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op), .cmd_data(b_data),
      .rsp_valid(b_rv), .rsp_data(b_rsp_data), .rsp_err(b_rerr), .shadow(b_shadow),
      .avm_address(b_addr), .avm_write(b_wr), .avm_read(b_rd), .avm_writedata(b_wd),
      .avm_readdata(b_rdata), .avm_waitrequest(1'b0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected per-cycle view of instance A, set by the model just after each edge.
   logic       chk_en = 1'b0;
   logic       e_ready, e_wr, e_rd, e_rv, e_rerr;
   logic [2:0] e_addr;
   logic [7:0] e_wd, e_rdata, e_shadow;
   logic [7:0] m_shadow;
   int         acc_cyc, rsp_cyc;
   logic [7:0] last_rsp;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_ready", 32'(a_ready), 32'(e_ready));
         chk("avm_write", 32'(a_wr), 32'(e_wr));
         chk("avm_read", 32'(a_rd), 32'(e_rd));
         chk("rsp_valid", 32'(a_rv), 32'(e_rv));
         chk("shadow", 32'(a_shadow), 32'(e_shadow));
         if (e_wr || e_rd) chk("avm_address", 32'(a_addr), 32'(e_addr));
         if (e_wr) chk("avm_writedata", a_wd, {24'b0, e_wd});
         if (e_rv) begin
            chk("rsp_data", 32'(a_rsp_data), 32'(e_rdata));
            chk("rsp_err", 32'(a_rerr), 32'(e_rerr));
         end
         if (a_rv) begin
            rsp_cyc  = cyc;
            last_rsp = a_rsp_data;
         end
      end
   end

   // One command on A; nwait = waitrequest-high cycles presented before release.
   task automatic cmd_a(input int op, input logic [7:0] data, input int nwait,
                        input logic [7:0] rdval);
      bit tout;
      int strobes;
      tout    = (TO != 0) && (nwait >= TO);
      strobes = tout ? TO : nwait + 1;
      a_valid = 1'b1;
      a_op    = 2'(op);
      a_data  = data;
      acc_cyc = cyc;
      @(posedge clk); #1;
      a_valid = 1'b0;
      e_ready = 1'b0;
      e_wr    = (op != 3);
      e_rd    = (op == 3);
      e_addr  = (op == 1) ? 3'd4 : (op == 2) ? 3'd5 : 3'd0;
      e_wd    = data;
      for (int i = 0; i < strobes; i++) begin
         a_wreq  = (i < nwait);
         a_rdata = (i == strobes - 1 && !tout) ? {24'hABCDEF, rdval} : {24'hFFFFFF, ~rdval};
         @(posedge clk); #1;
      end
      a_wreq  = 1'b0;
      a_rdata = 32'h0;
      e_wr    = 1'b0;
      e_rd    = 1'b0;
      e_rv    = 1'b1;
      if (tout) begin
         e_rdata = m_shadow;
         e_rerr  = 1'b1;
      end else if (op == 3) begin
         e_rdata = rdval;
         e_rerr  = (rdval != m_shadow);
      end else begin
         if (op == 0)      m_shadow = data;
         else if (op == 1) m_shadow = m_shadow | data;
         else              m_shadow = m_shadow & ~data;
         e_rdata = m_shadow;
         e_rerr  = 1'b0;
      end
      e_shadow = m_shadow;
      @(posedge clk); #1;
      e_rv    = 1'b0;
      e_ready = 1'b1;
   endtask

   // One command on B; readdata carries rdval only in the third cycle after accept.
   task automatic cmd_b(input int op, input logic [7:0] data, input logic [7:0] rdval,
                        output int rk, output logic [7:0] rd, output logic re);
      rk = 0;
      rd = 8'h00;
      re = 1'b0;
      b_valid = 1'b1;
      b_op    = 2'(op);
      b_data  = data;
      @(posedge clk); #1;
      b_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         b_rdata = (k == 3) ? {24'h123456, rdval} : {24'h0, ~rdval};
         @(negedge clk);
         chk("b_write", 32'(b_wr), 32'(op != 3 && k == 1));
         chk("b_read", 32'(b_rd), 32'(op == 3 && k == 1));
         if (b_rv) begin
            rk = k;
            rd = b_rsp_data;
            re = b_rerr;
         end
         @(posedge clk); #1;
      end
      b_rdata = 32'h0;
   endtask

   int         rk;
   logic [7:0] rd;
   logic       re;

   initial begin
      rst = 1'b1;
      a_valid = 1'b0; a_op = 2'd0; a_data = 8'h00; a_wreq = 1'b0; a_rdata = 32'h0;
      b_valid = 1'b0; b_op = 2'd0; b_data = 8'h00; b_rdata = 32'h0;
      m_shadow = 8'h00;
      e_ready = 1'b1; e_wr = 1'b0; e_rd = 1'b0; e_rv = 1'b0; e_rerr = 1'b0;
      e_addr = 3'd0; e_wd = 8'h00; e_rdata = 8'h00; e_shadow = 8'h00;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_address", 32'(a_addr), 32'h0);
      chk("reset_writedata", a_wd, 32'h0);
      chk("reset_rsp_data", 32'(a_rsp_data), 32'h0);
      chk("reset_rsp_err", 32'(a_rerr), 32'h0);
      chk("reset_b_ready", 32'(b_ready), 32'h1);

      cmd_a(0, 8'hA5, 0, 8'h00);
      chk("wr_latency", 32'(rsp_cyc - acc_cyc), 32'd2);
      chk("lit_shadow_a5", 32'(a_shadow), 32'hA5);
      cmd_a(1, 8'h0F, 0, 8'h00);
      chk("lit_shadow_af", 32'(a_shadow), 32'hAF);
      cmd_a(2, 8'h81, 0, 8'h00);
      chk("lit_shadow_2e", 32'(a_shadow), 32'h2E);

      cmd_a(3, 8'h00, 0, 8'h2E);
      chk("rd_latency", 32'(rsp_cyc - acc_cyc), 32'd2);
      cmd_a(3, 8'h00, 0, 8'h2F);
      chk("lit_mismatch_data", 32'(last_rsp), 32'h2F);
      chk("lit_shadow_kept", 32'(a_shadow), 32'h2E);

      cmd_a(0, 8'h3C, 3, 8'h00);
      chk("stall3_latency", 32'(rsp_cyc - acc_cyc), 32'd5);
      cmd_a(0, 8'h5A, TO - 1, 8'h00);
      cmd_a(0, 8'h77, 20, 8'h00);
      chk("lit_timeout_shadow", 32'(a_shadow), 32'h5A);
      chk("timeout_latency", 32'(rsp_cyc - acc_cyc), 32'(TO + 1));
      cmd_a(3, 8'h00, TO, 8'h5A);
      cmd_a(1, 8'h00, 0, 8'h00);
      cmd_a(2, 8'h00, 1, 8'h00);
      chk("lit_mask0_shadow", 32'(a_shadow), 32'h5A);

      // Reset while a SET is stalled in the request phase.
      a_valid = 1'b1; a_op = 2'd1; a_data = 8'hF0;
      @(posedge clk); #1;
      a_valid = 1'b0; a_wreq = 1'b1;
      e_ready = 1'b0; e_wr = 1'b1; e_addr = 3'd4; e_wd = 8'hF0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; a_wreq = 1'b0;
      e_wr = 1'b0; e_ready = 1'b1; m_shadow = 8'h00; e_shadow = 8'h00;
      repeat (4) @(posedge clk);
      #1;
      chk("lit_reset_shadow", 32'(a_shadow), 32'h0);
      cmd_a(1, 8'h11, 0, 8'h00);

      cmd_b(0, 8'h2E, 8'h00, rk, rd, re);
      chk("b_wr_rsp_cycle", 32'(rk), 32'd2);
      chk("b_shadow", 32'(b_shadow), 32'h2E);
      cmd_b(3, 8'h00, 8'h2E, rk, rd, re);
      chk("b_rd_rsp_cycle", 32'(rk), 32'd4);
      chk("b_rd_data", 32'(rd), 32'h2E);
      chk("b_rd_err", 32'(re), 32'h0);
      cmd_b(3, 8'h00, 8'h2F, rk, rd, re);
      chk("b_mismatch_data", 32'(rd), 32'h2F);
      chk("b_mismatch_err", 32'(re), 32'h1);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
